// File: rtl/tx_fifo_dispatch.sv
// Per-priority FIFO dispatcher: takes a one-hot grant from the scheduler, drains the
// selected crossbar FIFO through a 2-entry skid buffer onto the pMAC AXI-Stream port.
module tx_fifo_dispatch #(
  parameter int unsigned PORT_FIFO_PRI_NUM = 8,
  parameter int unsigned DATA_WIDTH        = 64
) (
  input  logic                                         i_clk,
  input  logic                                         i_rst,
  input  logic [PORT_FIFO_PRI_NUM:0]                   i_scheduing_rst,
  input  logic                                         i_scheduing_rst_vld,
  input  logic [PORT_FIFO_PRI_NUM:0]                   i_fifoc_empty,
  input  logic [(PORT_FIFO_PRI_NUM+1)*DATA_WIDTH-1:0]  i_fifoc_data,
  input  logic [PORT_FIFO_PRI_NUM:0]                   i_fifoc_last,
  output logic [PORT_FIFO_PRI_NUM:0]                   o_fifoc_rd_en,
  output logic [DATA_WIDTH-1:0]                        o_pmac_tx_axis_data,
  output logic                                         o_pmac_tx_axis_valid,
  output logic                                         o_pmac_tx_axis_last,
  input  logic                                         i_pmac_tx_axis_ready,
  output logic                                         o_tx_done,
  output logic [3:0]                                   o_tx_pri,
  output logic [15:0]                                  o_frame_len,
  output logic                                         o_sched_err
);

  localparam int unsigned P1 = PORT_FIFO_PRI_NUM + 1;
  localparam logic [P1-1:0] OneVec = P1'(1);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  state_e state_q, state_d;

  logic [P1-1:0]         q_oh_q;
  logic [3:0]            q_idx_q;
  logic [15:0]           beat_cnt_q;
  logic [15:0]           beat_next;

  logic [DATA_WIDTH-1:0] buf_data_q [2];
  logic [1:0]            buf_last_q;
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [1:0]            buf_cnt_q;

  logic                  tx_done_q;
  logic [3:0]            tx_pri_q;
  logic [15:0]           frame_len_q;
  logic                  sched_err_q;

  logic                  grant_onehot;
  logic                  grant_ok;
  logic                  grant_accept;
  logic                  grant_reject;
  logic [3:0]            grant_idx;

  logic                  sel_empty;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  out_valid;
  logic                  out_pop;
  logic                  buf_space;
  logic                  head_last;
  logic                  fifo_pop;
  logic                  frame_end;

  // Grant qualification
  always_comb begin
    grant_onehot = (i_scheduing_rst != '0) &&
                   ((i_scheduing_rst & (i_scheduing_rst - OneVec)) == '0);
    grant_ok     = grant_onehot && ((i_scheduing_rst & ~i_fifoc_empty) != '0);
    grant_accept = i_scheduing_rst_vld && (state_q == StIdle) && grant_ok;
    grant_reject = i_scheduing_rst_vld && !grant_accept;
    grant_idx    = '0;
    for (int unsigned k = 0; k < P1; k++) begin
      if (i_scheduing_rst[k]) grant_idx = 4'(k);
    end
  end

  // Head word of the latched queue, selected through its one-hot mask
  always_comb begin
    sel_empty = (q_oh_q & ~i_fifoc_empty) == '0;
    sel_last  = |(q_oh_q & i_fifoc_last);
    sel_data  = '0;
    for (int unsigned k = 0; k < P1; k++) begin
      if (q_oh_q[k]) sel_data = sel_data | i_fifoc_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    out_valid = buf_cnt_q != 2'd0;
    out_pop   = out_valid && i_pmac_tx_axis_ready;
    // A full buffer still accepts a word when its head leaves on the same edge
    buf_space = (buf_cnt_q != 2'd2) || out_pop;
    head_last = buf_last_q[rd_ptr_q];
    frame_end = (state_q == StDrain) && out_pop && head_last;
    beat_next = (beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1;
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_accept) state_d = StRead;
      StRead:  if (fifo_pop && sel_last) state_d = StDrain;
      StDrain: if (frame_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    fifo_pop      = (state_q == StRead) && !sel_empty && buf_space;
    o_fifoc_rd_en = fifo_pop ? q_oh_q : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      q_oh_q     <= '0;
      q_idx_q    <= '0;
      beat_cnt_q <= '0;
    end else if (grant_accept) begin
      q_oh_q     <= i_scheduing_rst;
      q_idx_q    <= grant_idx;
      beat_cnt_q <= '0;
    end else if (out_pop) begin
      beat_cnt_q <= beat_next;
    end
  end

  // Skid buffer: two-slot ring
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < 2; i++) buf_data_q[i] <= '0;
      buf_last_q <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      buf_cnt_q  <= 2'd0;
    end else begin
      if (fifo_pop) begin
        buf_data_q[wr_ptr_q] <= sel_data;
        buf_last_q[wr_ptr_q] <= sel_last;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (out_pop) rd_ptr_q <= ~rd_ptr_q;
      buf_cnt_q <= buf_cnt_q + 2'(fifo_pop) - 2'(out_pop);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tx_done_q   <= 1'b0;
      tx_pri_q    <= '0;
      frame_len_q <= '0;
      sched_err_q <= 1'b0;
    end else begin
      tx_done_q   <= frame_end;
      sched_err_q <= grant_reject;
      if (frame_end) begin
        tx_pri_q    <= q_idx_q;
        frame_len_q <= beat_next;
      end
    end
  end

  assign o_pmac_tx_axis_valid = out_valid;
  assign o_pmac_tx_axis_data  = out_valid ? buf_data_q[rd_ptr_q] : '0;
  assign o_pmac_tx_axis_last  = out_valid && head_last;
  assign o_tx_done            = tx_done_q;
  assign o_tx_pri             = tx_pri_q;
  assign o_frame_len          = frame_len_q;
  assign o_sched_err          = sched_err_q;

endmodule

// File: tb/tb_tx_fifo_dispatch.sv
// Scoreboard bench for tx_fifo_dispatch: FIFO models feed the DUT, expected beats and
// completions are queued at stimulus time and popped by a negedge monitor.
module tb_tx_fifo_dispatch;

  localparam int P1 = 9;
  localparam int DW = 64;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b0;
  logic [P1-1:0]        sched = '0;
  logic                 vld = 1'b0;
  logic [P1-1:0]        fifoc_empty;
  logic [P1*DW-1:0]     fifoc_data;
  logic [P1-1:0]        fifoc_last;
  logic [P1-1:0]        rd_en;
  logic [DW-1:0]        tdata;
  logic                 tvalid;
  logic                 tlast;
  logic                 tready = 1'b1;
  logic                 tx_done;
  logic [3:0]           tx_pri;
  logic [15:0]          frame_len;
  logic                 sched_err;

  tx_fifo_dispatch #(.PORT_FIFO_PRI_NUM(P1-1), .DATA_WIDTH(DW)) dut (
    .i_clk                (i_clk),
    .i_rst                (i_rst),
    .i_scheduing_rst      (sched),
    .i_scheduing_rst_vld  (vld),
    .i_fifoc_empty        (fifoc_empty),
    .i_fifoc_data         (fifoc_data),
    .i_fifoc_last         (fifoc_last),
    .o_fifoc_rd_en        (rd_en),
    .o_pmac_tx_axis_data  (tdata),
    .o_pmac_tx_axis_valid (tvalid),
    .o_pmac_tx_axis_last  (tlast),
    .i_pmac_tx_axis_ready (tready),
    .o_tx_done            (tx_done),
    .o_tx_pri             (tx_pri),
    .o_frame_len          (frame_len),
    .o_sched_err          (sched_err)
  );

  always #5 i_clk = ~i_clk;

  logic [DW:0]   fq [P1][$];
  logic [DW:0]   exp_beats [$];
  logic [19:0]   exp_done [$];
  int            n_vec = 0;
  int            n_fail = 0;
  int            err_cnt = 0;
  int            rd_cnt [P1];
  logic [P1-1:0] rd_snap = '0;
  logic          toggle_en = 1'b0;
  logic          ready_lvl = 1'b1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  function automatic logic [DW:0] beat_word(int k, int tag, int b, bit last);
    return {last, 16'hC0DE, 8'(k), 8'(tag), 16'h0000, 16'(b)};
  endfunction

  task automatic update_drive();
    logic [DW:0] w;
    for (int k = 0; k < P1; k++) begin
      if (fq[k].size() == 0) begin
        fifoc_empty[k]          = 1'b1;
        fifoc_data[k*DW +: DW]  = '0;
        fifoc_last[k]           = 1'b0;
      end else begin
        w                       = fq[k][0];
        fifoc_empty[k]          = 1'b0;
        fifoc_data[k*DW +: DW]  = w[DW-1:0];
        fifoc_last[k]           = w[DW];
      end
    end
  endtask

  task automatic load_frame(input int k, input int tag, input int n);
    for (int b = 0; b < n; b++) fq[k].push_back(beat_word(k, tag, b, b == n - 1));
    update_drive();
  endtask

  task automatic expect_frame(input int k, input int tag, input int first, input int n);
    for (int b = first; b < n; b++) exp_beats.push_back(beat_word(k, tag, b, b == n - 1));
    exp_done.push_back({4'(k), 16'(n - first)});
  endtask

  task automatic grant(input logic [P1-1:0] g);
    @(posedge i_clk); #1;
    sched = g;
    vld   = 1'b1;
    @(posedge i_clk); #1;
    vld   = 1'b0;
    sched = '0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      if (exp_done.size() == 0 && exp_beats.size() == 0) break;
      @(posedge i_clk);
    end
    check(name, 128'(exp_done.size() + exp_beats.size()), 128'd0);
  endtask

  function automatic int rd_total();
    int s = 0;
    for (int k = 0; k < P1; k++) s += rd_cnt[k];
    return s;
  endfunction

  // FIFO models pop what the DUT strobed on the edge just taken
  always @(posedge i_clk) begin
    #1;
    for (int k = 0; k < P1; k++) begin
      if (rd_snap[k]) begin
        if (fq[k].size() == 0) fail_now("pop_on_empty_fifo");
        else void'(fq[k].pop_front());
      end
    end
    rd_snap = '0;
    update_drive();
  end

  always @(posedge i_clk) begin
    #1;
    if (toggle_en) tready = ~tready;
    else tready = ready_lvl;
  end

  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Monitor
  always @(negedge i_clk) begin
    logic [DW:0]  e;
    logic [19:0]  d;
    if (!i_rst) begin
      rd_snap    = '0;
      prev_valid = 1'b0;
    end else begin
      rd_snap = rd_en;
      if (rd_en != '0) check("rd_en_onehot", 128'($countones(rd_en)), 128'd1);
      for (int k = 0; k < P1; k++) if (rd_en[k]) rd_cnt[k]++;
      if (prev_valid && !prev_ready)
        check("stall_hold", 128'({tvalid, tlast, tdata}), 128'({1'b1, prev_last, prev_data}));
      if (tvalid && tready) begin
        if (exp_beats.size() == 0) fail_now("beat_unexpected");
        else begin
          e = exp_beats.pop_front();
          check("beat", 128'({tlast, tdata}), 128'(e));
        end
      end
      if (tx_done) begin
        if (exp_done.size() == 0) fail_now("done_unexpected");
        else begin
          d = exp_done.pop_front();
          check("done_pri_len", 128'({tx_pri, frame_len}), 128'(d));
        end
      end
      if (sched_err) err_cnt++;
      prev_valid = tvalid;
      prev_ready = tready;
      prev_last  = tlast;
      prev_data  = tdata;
    end
  end

  initial begin
    #500000;
    fail_now("watchdog_timeout");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int eb;
    int rb;
    bit found;
    for (int k = 0; k < P1; k++) rd_cnt[k] = 0;
    update_drive();
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_outputs", 128'({tvalid, tlast, rd_en, tx_done, sched_err, tx_pri, frame_len}),
          128'd0);
    check("reset_data", 128'(tdata), 128'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    // Basic 4-beat frame on FIFO3, exact latency
    load_frame(3, 1, 4);
    expect_frame(3, 1, 0, 4);
    rb = rd_cnt[3];
    grant(9'h008);
    @(negedge i_clk);
    check("t1_valid_after_grant", 128'(tvalid), 128'd0);
    @(negedge i_clk);
    check("t1_first_beat_valid", 128'(tvalid), 128'd1);
    repeat (3) @(negedge i_clk);
    check("t1_last_on_4th", 128'({tvalid, tlast}), 128'd3);
    @(negedge i_clk);
    check("t1_done_timing", 128'(tx_done), 128'd1);
    wait_idle("t1_drained");
    check("t1_rd_pulses", 128'(rd_cnt[3] - rb), 128'd4);

    // Same frame with ready toggling
    load_frame(3, 2, 4);
    expect_frame(3, 2, 0, 4);
    rb = rd_cnt[3];
    toggle_en = 1'b1;
    grant(9'h008);
    wait_idle("t2_drained");
    toggle_en = 1'b0;
    ready_lvl = 1'b1;
    check("t2_rd_pulses", 128'(rd_cnt[3] - rb), 128'd4);

    // Rejected grants: multi-hot, zero-hot, empty FIFO
    eb = err_cnt;
    load_frame(2, 3, 1);
    load_frame(3, 4, 1);
    rb = rd_total();
    grant(9'h00C);
    grant(9'h000);
    grant(9'h020);
    repeat (3) @(posedge i_clk);
    check("t3_err_pulses", 128'(err_cnt - eb), 128'd3);
    check("t3_no_pops", 128'(rd_total() - rb), 128'd0);
    expect_frame(2, 3, 0, 1);
    grant(9'h004);
    wait_idle("t3_fifo2_drained");
    expect_frame(3, 4, 0, 1);
    grant(9'h008);
    wait_idle("t3_fifo3_drained");
    check("t3_no_extra_err", 128'(err_cnt - eb), 128'd3);

    // Grant while READ is rejected, frame unaffected
    eb = err_cnt;
    load_frame(4, 5, 4);
    load_frame(2, 6, 1);
    expect_frame(4, 5, 0, 4);
    grant(9'h010);
    grant(9'h004);
    wait_idle("t4_drained");
    check("t4_err_in_read", 128'(err_cnt - eb), 128'd1);
    check("t4_fifo2_untouched", 128'(fq[2].size()), 128'd1);
    expect_frame(2, 6, 0, 1);
    grant(9'h004);
    wait_idle("t4_fifo2_drained");

    // Reset after two beats of four
    load_frame(6, 7, 4);
    expect_frame(6, 7, 0, 4);
    grant(9'h040);
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    check("t5_outputs_in_reset", 128'({tvalid, tlast, rd_en, tx_done, sched_err}), 128'd0);
    check("t5_data_in_reset", 128'(tdata), 128'd0);
    check("t5_beats_seen", 128'(exp_beats.size()), 128'd2);
    exp_beats.delete();
    exp_done.delete();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    check("t5_fifo6_left", 128'(fq[6].size()), 128'd1);
    expect_frame(6, 7, 3, 4);
    grant(9'h040);
    wait_idle("t5_after_reset");
    check("t5_fifo6_empty", 128'(fq[6].size()), 128'd0);

    // Back-to-back: second grant lands in the o_tx_done cycle
    eb = err_cnt;
    load_frame(0, 8, 3);
    load_frame(7, 9, 2);
    expect_frame(0, 8, 0, 3);
    expect_frame(7, 9, 0, 2);
    grant(9'h001);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge i_clk);
      if (tx_done) found = 1'b1;
    end
    check("t6_first_done_seen", 128'(found), 128'd1);
    sched = 9'h080;
    vld   = 1'b1;
    @(posedge i_clk); #1;
    vld   = 1'b0;
    sched = '0;
    wait_idle("t6_drained");
    check("t6_no_err", 128'(err_cnt - eb), 128'd0);
    check("t6_fifos_empty", 128'(fq[0].size() + fq[7].size()), 128'd0);

    repeat (3) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_fifo_dispatch.md
TX_FIFO_DISPATCH -- requirements
Module: tx_fifo_dispatch

Interface
REQ-001 SHALL have parameter PORT_FIFO_PRI_NUM, default 8, number of priority FIFOs minus one; vector width is PORT_FIFO_PRI_NUM+1 (P1).
REQ-002 SHALL have parameter DATA_WIDTH, default 64, beat width in bits (DW).
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 i_clk  input  1  250MHz clock.
REQ-005 i_rst  input  1  asynchronous active-low reset.
REQ-006 i_scheduing_rst  input  P1  one-hot grant from the scheduling pipeline.
REQ-007 i_scheduing_rst_vld  input  1  grant valid, single-cycle pulse.
REQ-008 i_fifoc_empty  input  P1  per-priority crossbar FIFO empty, first-word-fall-through.
REQ-009 i_fifoc_data  input  P1*DW  head words; FIFO k at bits [k*DW +: DW].
REQ-010 i_fifoc_last  input  P1  head-word end-of-frame tag per FIFO.
REQ-011 o_fifoc_rd_en  output  P1  pop strobe; at most one bit high per cycle.
REQ-012 o_pmac_tx_axis_data  output  DW  beat data to QBU pMAC.
REQ-013 o_pmac_tx_axis_valid  output  1  beat valid.
REQ-014 o_pmac_tx_axis_last  output  1  final beat of frame.
REQ-015 i_pmac_tx_axis_ready  input  1  QBU ready.
REQ-016 o_tx_done  output  1  one-cycle pulse after a frame's last beat handshake.
REQ-017 o_tx_pri  output  4  index of the dispatched queue, valid with o_tx_done.
REQ-018 o_frame_len  output  16  beat count of finished frame, valid with o_tx_done.
REQ-019 o_sched_err  output  1  one-cycle pulse on a rejected grant.

Function
REQ-020 FSM states SHALL be IDLE, READ, DRAIN.
REQ-021 IDLE: on vld with exactly one grant bit set and that FIFO non-empty, latch index q, clear beat counter, go to READ next cycle.
REQ-022 IDLE: grant zero-hot, multi-hot, or naming an empty FIFO -> o_sched_err pulse next cycle, stay IDLE, no pop.
REQ-023 vld in READ or DRAIN SHALL be ignored and pulse o_sched_err.
REQ-024 Output path SHALL be a 2-entry skid buffer (data + last); valid = buffer non-empty; head pops on valid&&ready.
REQ-025 READ: rd_en[q] = !empty[q] && (buffer has a free slot, counting a same-cycle pop); popped word and i_fifoc_last[q] enter buffer same edge.
REQ-026 Sustained throughput SHALL be 1 beat/cycle while ready stays high and FIFO q non-empty.
REQ-027 Popping a word with last=1 SHALL move READ->DRAIN; no further pops in that frame.
REQ-028 FIFO q empty mid-frame: hold in READ, no pop, output gap permitted; no timeout.
REQ-029 DRAIN: when the last-tagged beat handshakes, go IDLE; o_tx_done, o_tx_pri=q, o_frame_len registered next cycle.
REQ-030 Beat counter SHALL increment per output handshake and saturate at 16'hFFFF.
REQ-031 Data/last SHALL stay stable while valid && !ready.
REQ-032 A new grant SHALL be accepted in the cycle o_tx_done is high (FSM already IDLE).
REQ-033 Output latency: first beat valid 2 cycles after accepted grant (IDLE->READ, then pop).

Reset
REQ-034 Reset low SHALL asynchronously force IDLE, flush skid buffer, zero counters; all outputs 0.
REQ-035 Reset mid-frame SHALL discard partial frame without o_tx_done; remaining FIFO words are not popped.
REQ-036 First grant SHALL be accepted no earlier than the first clock edge after reset deassertion.

Verification
REQ-037 FIFO3 holds 4 beats (last on 4th), ready=1, grant 9'h008 -> beats on cycles 2..5, last on 4th, rd_en[3] 4 pulses, o_tx_done with o_tx_pri=3, o_frame_len=4.
REQ-038 Same frame, ready toggling 1,0 -> data stable across stalls, no pop while buffer full, frame_len=4.
REQ-039 Grant 9'h00C, then 9'h000, then 9'h020 with FIFO5 empty -> three o_sched_err pulses, no rd_en, FSM IDLE.
REQ-040 Grant during READ -> o_sched_err, current frame unaffected.
REQ-041 Reset low after 2 of 4 beats -> outputs 0 immediately, no o_tx_done; new grant after release works.
REQ-042 Back-to-back frames on FIFO0 then FIFO7, second grant in o_tx_done cycle -> no dropped or duplicated beats.
